instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 13 +
 rtl/ifetch_fifo.sv | 47 ++++
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the instruction-fetch state encoding.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO with synchronous push/pop/flush and an occupancy count.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    count_q;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit with prefetch buffer and redirect handling.
// Define IFETCH_PC_TAG_EN to store a fetch PC per buffer entry and drive instr_pc.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                DEPTH    = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_take,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output fetch_state_e       state_o
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef IFETCH_PC_TAG_EN
  localparam int FW = INSTR_W + ADDR_W;
`else
  localparam int FW = INSTR_W;
`endif

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drop_pc_q, drop_pc_d;
  logic              xfer, push, pop;
  logic [CW-1:0]     count, count_next;
  logic [FW-1:0]     push_data, head;

  // Handshake: a request stays stable while mem_req=1 until mem_ack; a
  // transfer is an edge with mem_req=1 and mem_ack=1. Reset kills the request at once.
  assign mem_req     = (state_q != HOLD) && !reset;
  assign mem_addr    = pc_q;
  assign xfer        = mem_req && mem_ack;
  assign instr_valid = (count != '0);
  assign pop         = instr_take && instr_valid && !redirect;
  assign push        = xfer && (state_q == FETCH) && !redirect;
  assign count_next  = count + CW'(push) - CW'(pop);
  assign state_o     = state_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_pc_d = drop_pc_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (xfer) begin
            pc_d = redirect_pc;
          end else begin
            state_d   = DROP;
            drop_pc_d = redirect_pc;
          end
        end else if (xfer) begin
          pc_d = pc_q + 1'b1;
          if (count_next == FULL) state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = FETCH;
          pc_d    = redirect_pc;
        end else if (count_next != FULL) begin
          state_d = FETCH;
        end
      end
      DROP: begin
        // The outstanding word is thrown away; the newest redirect target wins.
        if (redirect) drop_pc_d = redirect_pc;
        if (xfer) begin
          state_d = FETCH;
          pc_d    = redirect ? redirect_pc : drop_pc_q;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      drop_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_pc_q <= drop_pc_d;
    end
  end

`ifdef IFETCH_PC_TAG_EN
  assign push_data = {mem_rdata, mem_addr};
  assign instr     = head[FW-1:ADDR_W];
  assign instr_pc  = head[ADDR_W-1:0];
`else
  assign push_data = mem_rdata;
  assign instr     = head;
  assign instr_pc  = '0;
`endif

  ifetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(FW)
  ) u_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .flush_i    (redirect),
    .head_o     (head),
    .count_o    (count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vectors, expected-instruction queue, negedge monitor.
module tb_instruction_fetch;
  import cpu_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         mem_req, mem_ack, instr_valid, instr_take, redirect;
  logic [15:0]  mem_addr, mem_rdata, instr, instr_pc, redirect_pc;
  fetch_state_e state;

  logic         mem_req2, instr_valid2;
  logic [15:0]  mem_addr2, mem_rdata2, instr2, instr_pc2;
  fetch_state_e state2;

  logic [31:0]  exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  // Memory model: word k holds k + 16'h1000.
  assign mem_rdata  = mem_addr + 16'h1000;
  assign mem_rdata2 = mem_addr2 + 16'h1000;

  instruction_fetch #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_take(instr_take), .instr_pc(instr_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .state_o(state)
  );

  instruction_fetch #(.RESET_PC(16'hFFFF), .DEPTH(4)) dut_wrap (
    .clock(clock), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(1'b1), .mem_rdata(mem_rdata2), .instr(instr2), .instr_valid(instr_valid2),
    .instr_take(1'b0), .instr_pc(instr_pc2), .redirect(1'b0),
    .redirect_pc(16'h0000), .state_o(state2)
  );

  // Clock
  always #5 clock = ~clock;

  function automatic logic [15:0] epc(input logic [15:0] a);
`ifdef IFETCH_PC_TAG_EN
    return a;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    instr_take = 1'b1;
    while (exp_q.size() != 0 && guard < 64) begin
      step();
      guard++;
    end
    instr_take = 1'b0;
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard monitor: every consumed instruction must match the queue head.
  always @(negedge clock) begin
    if (!reset && instr_valid && instr_take && !redirect) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_instr: got %h/%h expected none", instr, instr_pc);
      end else begin
        chk("consumed", {instr, instr_pc}, exp_q.pop_front());
      end
    end
  end

  // Request stability monitor: an unacknowledged request must persist unchanged.
  logic        pend = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  always @(negedge clock) begin
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) chk("req_stable", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, pend_addr});
      pend      = mem_req && !mem_ack;
      pend_addr = mem_addr;
    end
  end

  initial begin
    mem_ack     = 1'b1;
    instr_take  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    step();
    step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_pc", 32'(instr_pc), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_addr_wrap", 32'(mem_addr2), 32'hFFFF);

    reset = 1'b0;
    #1;
    chk("first_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0000});
    chk("first_state", 32'(state), 32'(FETCH));
    chk("wrap_first", {15'd0, mem_req2, mem_addr2}, {15'd0, 1'b1, 16'hFFFF});

    // Back-to-back fetches with ack tied high until the buffer fills.
    step();
    chk("e1_head", {15'd0, instr_valid, instr}, {15'd0, 1'b1, 16'h1000});
    chk("e1_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0001});
    chk("wrap_second", 32'(mem_addr2), 32'h0000);
    chk("wrap_head", {15'd0, instr_valid2, instr2}, {15'd0, 1'b1, 16'h0FFF});
    step();
    chk("full_req", 32'(mem_req), 32'd0);
    chk("full_state", 32'(state), 32'(HOLD));
    chk("full_head", {instr, instr_pc}, {16'h1000, epc(16'h0000)});
    step();
    chk("hold_ack_ignored", {15'd0, mem_req, mem_addr}, {15'd0, 1'b0, 16'h0002});

    exp_q.push_back({16'h1000, epc(16'h0000)});
    instr_take = 1'b1;
    step();
    instr_take = 1'b0;
    chk("refetch", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0002});
    chk("next_head", {instr, instr_pc}, {16'h1001, epc(16'h0001)});
    chk("wrap_full4", 32'(mem_req2), 32'd0);
    step();

    // Redirect together with take while two entries are buffered.
    chk("pre_redir_state", 32'(state), 32'(HOLD));
    redirect = 1'b1; redirect_pc = 16'h0020; instr_take = 1'b1;
    step();
    redirect = 1'b0; instr_take = 1'b0;
    chk("redir_flush", 32'(instr_valid), 32'd0);
    chk("redir_addr", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0020});
    for (int k = 0; k < 8; k++) exp_q.push_back({16'h1020 + 16'(k), epc(16'h0020 + 16'(k))});
    drain("stream");

    // Redirect coincident with a transfer.
    chk("pre_coinc_state", 32'(state), 32'(FETCH));
    redirect = 1'b1; redirect_pc = 16'h0070;
    step();
    chk("coinc", {14'd0, instr_valid, mem_req, mem_addr}, {14'd0, 1'b0, 1'b1, 16'h0070});
    redirect_pc = 16'h0005;
    step();
    chk("to5", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0005});

    // Stalled request at 5, redirected while waiting.
    mem_ack = 1'b0; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    chk("drop_state", 32'(state), 32'(DROP));
    chk("drop_addr1", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0005});
    step();
    chk("drop_addr2", 32'(mem_addr), 32'h0005);
    mem_ack = 1'b1;
    instr_take = 1'b1;
    exp_q.push_back({16'h1040, epc(16'h0040)});
    step();
    chk("drop_done", {14'd0, instr_valid, mem_req, mem_addr}, {14'd0, 1'b0, 1'b1, 16'h0040});
    drain("after_drop");

    // Two redirects while dropping: the later target wins.
    redirect = 1'b1; redirect_pc = 16'h0009;
    step();
    mem_ack = 1'b0; redirect_pc = 16'h0050;
    step();
    redirect_pc = 16'h0060;
    step();
    redirect = 1'b0;
    chk("drop2_state", 32'(state), 32'(DROP));
    chk("drop2_addr", 32'(mem_addr), 32'h0009);
    mem_ack = 1'b1;
    exp_q.push_back({16'h1060, epc(16'h0060)});
    step();
    chk("latest_wins", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0060});
    drain("after_drop2");

    // Reset while a request at 7 is outstanding.
    redirect = 1'b1; redirect_pc = 16'h0007;
    step();
    redirect = 1'b0; mem_ack = 1'b0;
    step();
    chk("pre_rst_addr", 32'(mem_addr), 32'h0007);
    reset = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_out", {instr_valid, instr, instr_pc}, {1'b0, 16'h0000, 16'h0000});
    chk("midrst_addr", 32'(mem_addr), 32'h0000);
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    #1;
    chk("rel_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0000});
    step();
    chk("rel_head", {instr_valid, instr, instr_pc}, {1'b1, 16'h1000, epc(16'h0000)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
